// File: rtl/mac_array_zskip_if.sv
// Bus bundle for mac_array_zskip: west/north feed, south psum output and
// the zero-row power reporting signals.
interface mac_array_zskip_if #(
  parameter int bw              = 4,
  parameter int psum_bw         = 16,
  parameter int row             = 8,
  parameter int col             = 8,
  parameter int channels_per_pe = 1,
  parameter int cnt_bw          = 32
);
  // No backpressure anywhere: inst_w qualifies the in_w slices every cycle,
  // and valid[c] qualifies out_s column c in exactly the cycle it is high.
  logic [row*channels_per_pe*bw-1:0] in_w;
  logic [1:0]                        inst_w;
  logic [psum_bw*col-1:0]            in_n;
  logic                              skip_en;
  logic [psum_bw*col-1:0]            out_s;
  logic [col-1:0]                    valid;
  logic [row-1:0]                    o_weight_zero_rows;
  logic [cnt_bw-1:0]                 skip_cnt;

  modport master (
    output in_w, inst_w, in_n, skip_en,
    input  out_s, valid, o_weight_zero_rows, skip_cnt
  );

  modport slave (
    input  in_w, inst_w, in_n, skip_en,
    output out_s, valid, o_weight_zero_rows, skip_cnt
  );
endinterface

// File: rtl/mac_array_zskip.sv
// Weight-stationary systolic MAC array; rows whose loaded kernel is all zero
// bypass their multipliers when skip_en is set and are counted in skip_cnt.
module mac_array_zskip #(
  parameter int bw              = 4,
  parameter int psum_bw         = 16,
  parameter int row             = 8,
  parameter int col             = 8,
  parameter int channels_per_pe = 1,
  parameter int cnt_bw          = 32
) (
  input logic             clk,
  input logic             reset,
  mac_array_zskip_if.slave bus
);
  localparam int aw = channels_per_pe * bw;

  logic [1:0]         inst_sk [row];
  logic [aw-1:0]      a_q     [row][col];
  logic [aw-1:0]      w_q     [row][col];
  logic [1:0]         i_q     [row][col];
  logic               ready_q [row][col];
  logic [psum_bw-1:0] psum_q  [row][col];
  logic               valid_q [row][col];
  logic [row-1:0]     zero_q;
  logic [cnt_bw-1:0]  cnt_q;

  logic [aw-1:0]      a_in    [row][col];
  logic [1:0]         inst_in [row][col];
  logic [psum_bw-1:0] n_in    [row][col];
  logic [psum_bw-1:0] mac     [row][col];
  logic [row-1:0]     zero_d;
  logic [cnt_bw-1:0]  cnt_d;
  logic [cnt_bw:0]    inc;
  logic [cnt_bw:0]    cnt_sum;

  // Modular arithmetic in psum_bw bits gives the sign-extended product's low bits.
  function automatic logic [psum_bw-1:0] dot(input logic [aw-1:0] a, input logic [aw-1:0] w);
    logic [psum_bw-1:0] acc, a_ext, w_ext;
    acc = '0;
    for (int k = 0; k < channels_per_pe; k++) begin
      a_ext = {{(psum_bw-bw){1'b0}}, a[k*bw +: bw]};
      w_ext = {{(psum_bw-bw){w[k*bw+bw-1]}}, w[k*bw +: bw]};
      acc   = acc + a_ext * w_ext;
    end
    return acc;
  endfunction

  always_comb begin
    for (int r = 0; r < row; r++) begin
      a_in[r][0]    = bus.in_w[r*aw +: aw];
      inst_in[r][0] = inst_sk[r];
      // A PE still waiting for its weight swallows the load bit.
      for (int c = 0; c < col-1; c++) begin
        a_in[r][c+1]    = a_q[r][c];
        inst_in[r][c+1] = {i_q[r][c][1], i_q[r][c][0] & ~ready_q[r][c]};
      end
    end
    for (int c = 0; c < col; c++) begin
      n_in[0][c] = bus.in_n[c*psum_bw +: psum_bw];
      for (int r = 0; r < row-1; r++) n_in[r+1][c] = psum_q[r][c];
    end
  end

  always_comb begin
    zero_d = '0;
    inc    = '0;
    for (int r = 0; r < row; r++) begin
      zero_d[r] = 1'b1;
      for (int c = 0; c < col; c++) begin
        zero_d[r] = zero_d[r] & ~ready_q[r][c] & (w_q[r][c] == '0);
        if (bus.skip_en && zero_q[r])
          mac[r][c] = n_in[r][c] + dot('0, '0);
        else
          mac[r][c] = n_in[r][c] + dot(a_q[r][c], w_q[r][c]);
      end
      if (bus.skip_en && zero_q[r] && i_q[r][0][1])
        inc = inc + {{cnt_bw{1'b0}}, 1'b1};
    end
    cnt_sum = {1'b0, cnt_q} + inc;
    cnt_d   = cnt_sum[cnt_bw] ? '1 : cnt_sum[cnt_bw-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < row; r++) begin
        inst_sk[r] <= '0;
        for (int c = 0; c < col; c++) begin
          a_q[r][c]     <= '0;
          w_q[r][c]     <= '0;
          i_q[r][c]     <= '0;
          ready_q[r][c] <= 1'b1;
          psum_q[r][c]  <= '0;
          valid_q[r][c] <= 1'b0;
        end
      end
      zero_q <= '0;
      cnt_q  <= '0;
    end else begin
      // Load and execute together is illegal; load takes precedence.
      inst_sk[0] <= {bus.inst_w[1] & ~bus.inst_w[0], bus.inst_w[0]};
      for (int r = 0; r < row-1; r++) inst_sk[r+1] <= inst_sk[r];
      for (int r = 0; r < row; r++) begin
        for (int c = 0; c < col; c++) begin
          a_q[r][c] <= a_in[r][c];
          i_q[r][c] <= inst_in[r][c];
          if (i_q[r][c][0] && ready_q[r][c]) begin
            w_q[r][c]     <= a_q[r][c];
            ready_q[r][c] <= 1'b0;
          end
          valid_q[r][c] <= i_q[r][c][1];
          if (i_q[r][c][1]) psum_q[r][c] <= mac[r][c];
        end
      end
      zero_q <= zero_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    for (int c = 0; c < col; c++) begin
      bus.out_s[c*psum_bw +: psum_bw] = psum_q[row-1][c];
      bus.valid[c]                    = valid_q[row-1][c];
    end
  end

  assign bus.o_weight_zero_rows = zero_q;
  assign bus.skip_cnt           = cnt_q;
endmodule

// File: tb/tb_mac_array_zskip.sv
// Bench for mac_array_zskip: a 16-bit/32-bit-counter array and an 8-bit/3-bit
// copy share the same skewed stimulus; a scoreboard checks values and latency.
module tb_mac_array_zskip;
  localparam int row = 2;
  localparam int col = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_array_zskip_if #(.bw(4), .psum_bw(16), .row(row), .col(col), .channels_per_pe(1), .cnt_bw(32)) bus_a ();
  mac_array_zskip_if #(.bw(4), .psum_bw(8),  .row(row), .col(col), .channels_per_pe(1), .cnt_bw(3))  bus_b ();

  mac_array_zskip #(.bw(4), .psum_bw(16), .row(row), .col(col), .channels_per_pe(1), .cnt_bw(32))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  mac_array_zskip #(.bw(4), .psum_bw(8), .row(row), .col(col), .channels_per_pe(1), .cnt_bw(3))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_b.in_w    = bus_a.in_w;
  assign bus_b.inst_w  = bus_a.inst_w;
  assign bus_b.skip_en = bus_a.skip_en;
  assign bus_b.in_n    = {bus_a.in_n[23:16], bus_a.in_n[7:0]};

  typedef struct packed { logic [3:0] a0; logic [3:0] a1; logic [15:0] n; } item_t;
  typedef struct { logic [3:0] a0; logic [3:0] a1; logic [15:0] n; logic [15:0] e0; logic [15:0] e1; } vec_t;

  item_t       pipe [3];
  vec_t        vt [6];
  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One issue slot: in_w row r carries the item issued r+1 edges earlier,
  // in_n column c the item issued c+2 edges earlier.
  task automatic step(input logic [1:0] inst, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [15:0] n, input bit push, input logic [15:0] e0, input logic [15:0] e1);
    @(negedge clk); #1;
    bus_a.inst_w = inst;
    bus_a.in_w   = {pipe[1].a1, pipe[0].a0};
    bus_a.in_n   = {pipe[2].n, pipe[1].n};
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = {a0, a1, n};
    if (push) begin
      exp_q0.push_back({32'(cyc + 1 + row + 1), e0});
      exp_q1.push_back({32'(cyc + 1 + row + 2), e1});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 4'd0, 4'd0, 16'd0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic exec(input logic [3:0] a0, input logic [3:0] a1, input logic [15:0] n,
                      input logic [15:0] e0, input logic [15:0] e1);
    step(2'b10, a0, a1, n, 1'b1, e0, e1);
  endtask

  // Load vector k lands in column k of every row.
  task automatic load_w(input logic [3:0] w00, input logic [3:0] w01, input logic [3:0] w10, input logic [3:0] w11);
    step(2'b01, w00, w10, 16'd0, 1'b0, 16'd0, 16'd0);
    step(2'b01, w01, w11, 16'd0, 1'b0, 16'd0, 16'd0);
    idle(6);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus_a.in_w    = 8'($urandom_range(0, 255));
      bus_a.inst_w  = 2'($urandom_range(0, 3));
      bus_a.in_n    = $urandom;
      bus_a.skip_en = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_out_a",   bus_a.out_s, 32'd0);
      chk("rst_valid_a", 32'(bus_a.valid), 32'd0);
      chk("rst_zero_a",  32'(bus_a.o_weight_zero_rows), 32'd0);
      chk("rst_cnt_a",   bus_a.skip_cnt, 32'd0);
      chk("rst_out_b",   32'(bus_b.out_s), 32'd0);
      chk("rst_valid_b", 32'(bus_b.valid), 32'd0);
      chk("rst_cnt_b",   32'(bus_b.skip_cnt), 32'd0);
      #1;
    end
    reset = 1'b0;
    bus_a.in_w = '0; bus_a.inst_w = '0; bus_a.in_n = '0; bus_a.skip_en = 1'b0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic mon(input int c, input logic va, input logic vb, input logic [15:0] oa, input logic [7:0] ob);
    logic [47:0] e;
    bit          has, exp_v;
    e   = '0;
    has = 1'b0;
    if (c == 0 && exp_q0.size() > 0) begin e = exp_q0[0]; has = 1'b1; end
    if (c == 1 && exp_q1.size() > 0) begin e = exp_q1[0]; has = 1'b1; end
    exp_v = has && (e[47:16] == 32'(cyc));
    if (va || vb || exp_v) begin
      chk($sformatf("valid_a[%0d]", c), 32'(va), 32'(exp_v));
      chk($sformatf("valid_b[%0d]", c), 32'(vb), 32'(exp_v));
      if (exp_v) begin
        chk($sformatf("out_a[%0d]", c), 32'(oa), 32'(e[15:0]));
        chk($sformatf("out_b[%0d]", c), 32'(ob), 32'(e[7:0]));
        if (c == 0) exp_q0.delete(0); else exp_q1.delete(0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, bus_a.valid[0], bus_b.valid[0], bus_a.out_s[15:0],  bus_b.out_s[7:0]);
      mon(1, bus_a.valid[1], bus_b.valid[1], bus_a.out_s[31:16], bus_b.out_s[15:8]);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Weights row0 {3,-2}, row1 {1,4}: col0 = n+3*a0+a1, col1 = n-2*a0+4*a1.
    vt[0] = '{4'd5,  4'd2,  16'd0,     16'd17,    16'hFFFE};
    vt[1] = '{4'd15, 4'd15, 16'd0,     16'd60,    16'd30};
    vt[2] = '{4'd0,  4'd0,  16'd100,   16'd100,   16'd100};
    vt[3] = '{4'd7,  4'd0,  16'hFFFB,  16'd16,    16'hFFED};
    vt[4] = '{4'd1,  4'd9,  16'd1000,  16'd1012,  16'd1034};
    vt[5] = '{4'd12, 4'd3,  16'h7FFF,  16'h8026,  16'h7FF3};

    do_reset();

    // Load and execute through the full table, skip_en toggling (no zero rows).
    load_w(4'd3, 4'hE, 4'd1, 4'd4);
    chk("zero_rows_a_none", 32'(bus_a.o_weight_zero_rows), 32'd0);
    chk("zero_rows_b_none", 32'(bus_b.o_weight_zero_rows), 32'd0);
    for (int i = 0; i < 6; i++) begin
      bus_a.skip_en = 1'(i % 2);
      exec(vt[i].a0, vt[i].a1, vt[i].n, vt[i].e0, vt[i].e1);
    end
    idle(6);
    chk("cnt_a_noskip", bus_a.skip_cnt, 32'd0);

    // Zero row1: skipping and non-skipping must agree; only skips count.
    do_reset();
    load_w(4'd3, 4'hE, 4'd0, 4'd0);
    chk("zero_rows_a_r1", 32'(bus_a.o_weight_zero_rows), 32'd2);
    chk("zero_rows_b_r1", 32'(bus_b.o_weight_zero_rows), 32'd2);
    for (int pass = 0; pass < 2; pass++) begin
      bus_a.skip_en = (pass == 0);
      for (int i = 0; i < 4; i++)
        exec(vt[i].a0, vt[i].a1, vt[i].n,
             16'(int'(vt[i].n) + 3 * int'(vt[i].a0)),
             16'(int'(vt[i].n) - 2 * int'(vt[i].a0)));
      idle(6);
      chk("cnt_a_zero_row", bus_a.skip_cnt, 32'd4);
      chk("cnt_b_zero_row", 32'(bus_b.skip_cnt), 32'd4);
    end

    // Wrap: 127 + 1*1 is 128 in 16 bits and -128 in the 8-bit copy.
    do_reset();
    load_w(4'd1, 4'd0, 4'd0, 4'd0);
    chk("zero_rows_a_wrap", 32'(bus_a.o_weight_zero_rows), 32'd2);
    exec(4'd1, 4'd0, 16'd127, 16'h0080, 16'h007F);
    idle(6);

    // Reset lands while valid[1] of an execute is still in flight.
    do_reset();
    load_w(4'd3, 4'hE, 4'd1, 4'd4);
    exec(vt[0].a0, vt[0].a1, vt[0].n, vt[0].e0, vt[0].e1);
    idle(3);
    do_reset();
    idle(6);
    chk("valid_a_after_abort", 32'(bus_a.valid), 32'd0);
    load_w(4'd3, 4'hE, 4'd1, 4'd4);
    exec(vt[1].a0, vt[1].a1, vt[1].n, vt[1].e0, vt[1].e1);
    exec(vt[4].a0, vt[4].a1, vt[4].n, vt[4].e0, vt[4].e1);
    idle(6);

    // Saturation: both rows zero, two skip events per execute.
    do_reset();
    load_w(4'd0, 4'd0, 4'd0, 4'd0);
    chk("zero_rows_a_all", 32'(bus_a.o_weight_zero_rows), 32'd3);
    bus_a.skip_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] n;
      n = 16'($urandom);
      exec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), n, n, n);
    end
    idle(6);
    chk("cnt_a_sat10", bus_a.skip_cnt, 32'd20);
    chk("cnt_b_sat10", 32'(bus_b.skip_cnt), 32'd7);
    for (int i = 0; i < 2; i++) exec(4'd9, 4'd3, 16'd55, 16'd55, 16'd55);
    idle(6);
    chk("cnt_a_sat12", bus_a.skip_cnt, 32'd24);
    chk("cnt_b_hold", 32'(bus_b.skip_cnt), 32'd7);

    chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
